hdp_spi_loader: RTL and testbench
=================================

Name: hdp_spi_loader

Overview:
- Single-clock SPI master that drives the debug/boot SPI slave pins of the rv151 SoC: io_scs, io_sdi, io_sck, io_sdo.
- Sits directly upstream of the SoC's serial debug port. Accepts parallel frames on a valid/ready interface, shifts them out in SPI mode 0, and returns the full-duplex captured word.
- Used for program load and debug register access while the SoC runs from the same clk/rst domain.

Parameters:
- FRAME_W, 32, bits per frame; legal range 2..64.
- CLK_DIV, 4, clk cycles per SCK half-period; legal values 1..255.
- GAP_MIN, 2, minimum clk cycles io_scs stays high between transactions; legal values 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tx_valid  in  1  frame request.
- tx_ready  out  1  frame accepted when tx_valid && tx_ready.
- tx_data  in  FRAME_W  frame to shift out.
- tx_last  in  1  deassert io_scs after this frame.
- abort  in  1  synchronous; terminates the transaction.
- rx_valid  out  1  one-cycle pulse; rx_data valid.
- rx_data  out  FRAME_W  bits captured from io_sdo.
- busy  out  1  high whenever io_scs is low or the gap is running.
- io_scs  out  1  chip select, active-low.
- io_sck  out  1  SPI clock; idles low.
- io_sdi  out  1  master-out data to the SoC.
- io_sdo  in  1  master-in data from the SoC.

Behaviour:
- Reset values: io_scs=1, io_sck=0, io_sdi=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0. Reset asserts asynchronously, including mid-frame; there is no rx_valid on a reset abort. tx_ready rises on the first clk after rst deasserts.
- States:
  - IDLE: tx_ready=1.
  - SETUP: io_scs=0, first bit driven on io_sdi, hold CLK_DIV cycles.
  - SHIFT: FRAME_W SCK pulses, each CLK_DIV high then CLK_DIV low.
  - DONE: one cycle; pulse rx_valid.
  - HOLD: io_scs stays low, tx_ready=1, waiting for the next frame.
  - GAP: io_scs=1 for GAP_MIN cycles.
- Transitions:
  - IDLE→SETUP on accept.
  - SETUP→SHIFT after CLK_DIV cycles.
  - SHIFT→DONE after the falling edge of the last pulse.
  - DONE→GAP if the latched tx_last=1, else DONE→HOLD.
  - HOLD→SHIFT on accept; first bit is driven on the accept cycle, no SETUP phase.
  - GAP→IDLE after GAP_MIN cycles.
- Data timing:
  - MSB first.
  - io_sdi changes only while io_sck is low: on entering SETUP, and at each falling edge for the next bit.
  - io_sdo is sampled on the clk cycle where io_sck rises.
  - io_sck, io_scs and io_sdi are registered outputs.
- Latency: rx_valid asserts exactly 1 + CLK_DIV*(2*FRAME_W+1) cycles after an accept from IDLE. rx_data holds until the next rx_valid. There is no rx backpressure.
- tx_data and tx_last are latched on accept; later changes have no effect.
- abort:
  - In SETUP/SHIFT/DONE/HOLD: next cycle io_sck=0, io_sdi=0, enter GAP (io_scs=1), no rx_valid.
  - In IDLE/GAP: ignored.
  - abort together with tx_valid in IDLE: abort wins and the frame is not accepted (tx_ready is gated by abort).
- busy = (state != IDLE).

Optional Feature:
- Macro: HDP_SPI_LOADER_LSB_FIRST_EN.
- Defined: frames are shifted LSB first and rx_data is assembled LSB first; timing is unchanged.
- Undefined: MSB first as above.

Decomposition:
- Package hdp_spi_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, DONE, HOLD, GAP);
  - default constants for FRAME_W, CLK_DIV and GAP_MIN;
  - a function computing counter widths.
- Sub-module hdp_spi_clkgen: divider producing sck_rise/sck_fall strobes and the io_sck level from an enable. It restarts its phase on enable and has no other state.

Test Plan:
- FRAME_W=8, CLK_DIV=2, tx_data=0xA5, tx_last=1, slave model returns 0x3C:
  - io_sdi bits at rising edges are 1,0,1,0,0,1,0,1.
  - rx_valid at cycle 35 after accept, rx_data=0x3C.
  - io_scs high for GAP_MIN cycles, then tx_ready=1.
- Two frames, 0x12 with tx_last=0 then 0x34 with tx_last=1: io_scs stays low across both, exactly 16 SCK rising edges, two rx_valid pulses.
- abort asserted at the 4th rising edge of a 0xFF frame: io_sck=0 and io_scs=1 the next cycle, no rx_valid; a following 0x00 frame completes normally.
- rst asserted mid-SHIFT: io_scs=1 and io_sck=0 without waiting for a clk edge; after release tx_ready=1 and no rx_valid pulse.
- CLK_DIV=1, FRAME_W=32, 0xDEADBEEF loopback (io_sdo tied to io_sdi): rx_data=0xDEADBEEF at cycle 66.
- Macro defined, 0x01 sent with FRAME_W=8: first io_sdi bit is 1, remaining seven bits are 0.

Source files
------------

// File: rtl/hdp_spi_pkg.sv
// Shared types and helpers for the hdp_spi_loader SPI master.
// Contents: the loader FSM state enum, the default parameter values, and a
// helper that sizes counters from their largest value.
package hdp_spi_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE,
        HOLD,
        GAP
    } state_t;

    // Default configuration
    localparam int unsigned FRAME_W_DEF = 32;
    localparam int unsigned CLK_DIV_DEF = 4;
    localparam int unsigned GAP_MIN_DEF = 2;

    // Bits needed to hold values 0..max_val (never less than one bit)
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hdp_spi_clkgen.sv
// SCK divider for hdp_spi_loader.
// While en is high, io_sck toggles every CLK_DIV clk cycles, starting low.
// Dropping en returns the divider to phase zero with the clock parked low.
//   clk, rst      : system clock, asynchronous active-high reset
//   en            : run the divider; low clears the phase and parks sck low
//   park          : suppress the next rising edge (sck stays low)
//   sck           : registered SPI clock level
//   sck_rise_c    : strobe, sck goes high at the end of this cycle
//   sck_fall_c    : strobe, sck goes low at the end of this cycle
module hdp_spi_clkgen
    import hdp_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic park,
    output logic sck,
    output logic sck_rise_c,
    output logic sck_fall_c
);

    localparam int unsigned    DIV_W    = cnt_w(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             half_done_c;

    // Half-period boundary: the level flips at the end of this cycle
    assign half_done_c = en && (div_cnt == DIV_LAST);
    assign sck_rise_c  = half_done_c && !sck;
    assign sck_fall_c  = half_done_c && sck;

    // Phase counter and sck level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (half_done_c) begin
            div_cnt <= '0;
            sck     <= park ? 1'b0 : !sck;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/hdp_spi_loader.sv
// SPI mode-0 master feeding the rv151 serial debug/boot port.
// Frames arrive on a valid/ready interface, are shifted out on io_sdi while
// io_sdo is captured full-duplex, and the captured word is returned on
// rx_data with a one-cycle rx_valid pulse. Frames without tx_last keep io_scs
// low so the next frame continues the same transaction.
// Build option: define HDP_SPI_LOADER_LSB_FIRST_EN to shift and assemble
// frames LSB first (timing unchanged); MSB first otherwise.
//   clk, rst                    : system clock, asynchronous active-high reset
//   tx_valid/tx_ready           : frame handshake (tx_ready gated by abort)
//   tx_data, tx_last            : frame payload, end-of-transaction flag
//   abort                       : terminate the running transaction
//   rx_valid, rx_data           : captured frame, one-cycle valid pulse
//   busy                        : high outside IDLE
//   io_scs, io_sck, io_sdi      : chip select (active low), clock, MOSI
//   io_sdo                      : MISO from the SoC
module hdp_spi_loader
    import hdp_spi_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEF,
    parameter int unsigned CLK_DIV = CLK_DIV_DEF,
    parameter int unsigned GAP_MIN = GAP_MIN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tx_valid,
    output logic               tx_ready,
    input  logic [FRAME_W-1:0] tx_data,
    input  logic               tx_last,
    input  logic               abort,
    output logic               rx_valid,
    output logic [FRAME_W-1:0] rx_data,
    output logic               busy,
    output logic               io_scs,
    output logic               io_sck,
    output logic               io_sdi,
    input  logic               io_sdo
);

    localparam int unsigned      BIT_W    = cnt_w(FRAME_W);
    localparam int unsigned      GAP_W    = cnt_w(GAP_MIN - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MIN - 1);

    state_t             state;
    state_t             state_nxt;
    logic               tx_ready_q;
    logic               last_q;
    logic [FRAME_W-1:0] tx_sh;
    logic [FRAME_W-1:0] rx_sh;
    logic [BIT_W-1:0]   bit_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic               accept_c;
    logic               abort_act_c;
    logic               clk_en_c;
    logic               park_c;
    logic               sck_rise_c;
    logic               sck_fall_c;
    logic               first_bit_c;
    logic               next_bit_c;
    logic [FRAME_W-1:0] tx_shift_c;
    logic [FRAME_W-1:0] rx_shift_c;

    // Handshake; a same-cycle abort blocks the accept
    assign tx_ready    = tx_ready_q && !abort;
    assign accept_c    = tx_valid && tx_ready;
    assign abort_act_c = abort && ((state == SETUP) || (state == SHIFT) ||
                                   (state == DONE)  || (state == HOLD));

    // SETUP doubles as the first low half-period, so the divider runs through
    // both states; once all bits are in, the final rise is suppressed and its
    // strobe marks the end of the trailing low half.
    assign clk_en_c = ((state == SETUP) || (state == SHIFT)) && !abort;
    assign park_c   = (bit_cnt == BIT_LAST);

    // Bit ordering
`ifdef HDP_SPI_LOADER_LSB_FIRST_EN
    assign first_bit_c = tx_data[0];
    assign next_bit_c  = tx_sh[1];
    assign tx_shift_c  = tx_sh >> 1;
    assign rx_shift_c  = {io_sdo, rx_sh[FRAME_W-1:1]};
`else
    assign first_bit_c = tx_data[FRAME_W-1];
    assign next_bit_c  = tx_sh[FRAME_W-2];
    assign tx_shift_c  = tx_sh << 1;
    assign rx_shift_c  = {rx_sh[FRAME_W-2:0], io_sdo};
`endif

    hdp_spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk        (clk),
        .rst        (rst),
        .en         (clk_en_c),
        .park       (park_c),
        .sck        (io_sck),
        .sck_rise_c (sck_rise_c),
        .sck_fall_c (sck_fall_c)
    );

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_c) state_nxt = SETUP;
            end
            SETUP: begin
                if (abort)           state_nxt = GAP;
                else if (sck_rise_c) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (abort)                     state_nxt = GAP;
                else if (sck_rise_c && park_c) state_nxt = DONE;
            end
            DONE: begin
                if (abort || last_q) state_nxt = GAP;
                else                 state_nxt = HOLD;
            end
            HOLD: begin
                if (abort)         state_nxt = GAP;
                else if (accept_c) state_nxt = SHIFT;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, registered outputs and shift datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx_ready_q <= 1'b0;
            busy       <= 1'b0;
            io_scs     <= 1'b1;
            io_sdi     <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            last_q     <= 1'b0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            tx_ready_q <= (state_nxt == IDLE) || (state_nxt == HOLD);
            busy       <= (state_nxt != IDLE);
            io_scs     <= (state_nxt == IDLE) || (state_nxt == GAP);
            gap_cnt    <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;

            // Captured word is published only by a DONE that is not aborted
            rx_valid <= (state == DONE) && !abort;
            if ((state == DONE) && !abort) begin
                rx_data <= rx_sh;
            end

            // MOSI: first bit on accept, next bit on every falling edge
            if (accept_c) begin
                tx_sh   <= tx_data;
                last_q  <= tx_last;
                bit_cnt <= '0;
                io_sdi  <= first_bit_c;
            end else if (abort_act_c) begin
                io_sdi <= 1'b0;
            end else if (sck_fall_c) begin
                tx_sh  <= tx_shift_c;
                io_sdi <= next_bit_c;
            end

            // MISO sampled on the cycle io_sck rises
            if (sck_rise_c && !park_c) begin
                rx_sh   <= rx_shift_c;
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hdp_spi_loader.sv
// Directed testbench for hdp_spi_loader.
// dut   : FRAME_W=8,  CLK_DIV=2, GAP_MIN=2 with a mode-0 slave model.
// dut32 : FRAME_W=32, CLK_DIV=1, GAP_MIN=2 with io_sdo looped to io_sdi.
module tb_hdp_spi_loader;

`ifdef HDP_SPI_LOADER_LSB_FIRST_EN
    localparam logic [7:0]  EXP_RX_96   = 8'h69;
    localparam logic [7:0]  EXP_RX_E1   = 8'h87;
    localparam logic [7:0]  EXP_SDI_01  = 8'h80;
    localparam logic [15:0] EXP_SDI_B2B = 16'h482C;
`else
    localparam logic [7:0]  EXP_RX_96   = 8'h96;
    localparam logic [7:0]  EXP_RX_E1   = 8'hE1;
    localparam logic [7:0]  EXP_SDI_01  = 8'h01;
    localparam logic [15:0] EXP_SDI_B2B = 16'h1234;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_valid, tx_ready, tx_last, abort;
    logic [7:0]  tx_data, rx_data;
    logic        rx_valid, busy;
    logic        io_scs, io_sck, io_sdi, io_sdo;

    logic        w_valid, w_ready, w_last;
    logic [31:0] w_data, w_rx_data;
    logic        w_rx_valid, w_busy, w_scs, w_sck, w_sdi;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    hdp_spi_loader #(.FRAME_W(8), .CLK_DIV(2), .GAP_MIN(2)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_last(tx_last), .abort(abort),
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
        .io_scs(io_scs), .io_sck(io_sck), .io_sdi(io_sdi), .io_sdo(io_sdo)
    );

    hdp_spi_loader #(.FRAME_W(32), .CLK_DIV(1), .GAP_MIN(2)) dut32 (
        .clk(clk), .rst(rst), .tx_valid(w_valid), .tx_ready(w_ready),
        .tx_data(w_data), .tx_last(w_last), .abort(1'b0),
        .rx_valid(w_rx_valid), .rx_data(w_rx_data), .busy(w_busy),
        .io_scs(w_scs), .io_sck(w_sck), .io_sdi(w_sdi), .io_sdo(w_sdi)
    );

    // Mode-0 slave: word presented MSB first, advancing on each SCK fall
    logic [63:0] slave_bits = '0;
    int unsigned s_idx = 0;
    always @(negedge io_sck or posedge io_scs) begin
        if (io_scs) s_idx <= 0;
        else        s_idx <= s_idx + 1;
    end
    assign io_sdo = (s_idx < 64) ? slave_bits[63 - s_idx] : 1'b0;

    // Monitors
    logic sdi_log [0:255];
    int   log_n     = 0;
    int   sck_rises = 0;
    int   scs_rises = 0;
    int   rxv_cnt   = 0;
    always @(posedge io_sck) begin
        if (log_n < 256) sdi_log[log_n] = io_sdi;
        log_n     = log_n + 1;
        sck_rises = sck_rises + 1;
    end
    always @(posedge io_scs) scs_rises = scs_rises + 1;
    always @(posedge clk) if (rx_valid) rxv_cnt <= rxv_cnt + 1;

    task automatic start_frame(input logic [7:0] data, input logic last, output bit ok);
        int n = 0;
        while (!tx_ready && n < 100) begin
            @(posedge clk); @(negedge clk); n++;
        end
        ok = tx_ready;
        if (ok) begin
            tx_valid = 1'b1; tx_data = data; tx_last = last;
            @(posedge clk); @(negedge clk);
            tx_valid = 1'b0; tx_data = ~data; tx_last = ~last;
        end
    endtask

    task automatic wait_rx(output int lat);
        lat = 0;
        while (!rx_valid && lat < 200) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        if (!rx_valid) lat = -1;
    endtask

    task automatic wait_rises(input int target, output bit ok);
        int n = 0;
        while (sck_rises < target && n < 200) begin
            @(posedge clk); @(negedge clk); n++;
        end
        ok = (sck_rises >= target);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0; abort = 1'b0;
        w_valid = 1'b0; w_data = '0; w_last = 1'b0;
        @(posedge clk); @(negedge clk);
        total_cnt++; if (io_scs !== 1'b1)   $display("FAIL reset_scs: got %b want 1", io_scs);     else pass_cnt++;
        total_cnt++; if (io_sck !== 1'b0)   $display("FAIL reset_sck: got %b want 0", io_sck);     else pass_cnt++;
        total_cnt++; if (io_sdi !== 1'b0)   $display("FAIL reset_sdi: got %b want 0", io_sdi);     else pass_cnt++;
        total_cnt++; if (tx_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", tx_ready); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_rxv: got %b want 0", rx_valid);  else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_rxd: got %h want 00", rx_data);   else pass_cnt++;
        total_cnt++; if (busy !== 1'b0)     $display("FAIL reset_busy: got %b want 0", busy);       else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if (tx_ready !== 1'b0) $display("FAIL release_ready_early: got %b want 0", tx_ready); else pass_cnt++;
        @(posedge clk); @(negedge clk);
        total_cnt++; if (tx_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", tx_ready); else pass_cnt++;
    endtask

    task automatic test_single_frame();
        bit ok; int lat; int base; logic [7:0] got;
        slave_bits = {8'h3C, 56'h0};
        base = log_n;
        start_frame(8'hA5, 1'b1, ok);
        total_cnt++; if (!ok) $display("FAIL single_accept: got no tx_ready want ready"); else pass_cnt++;
        wait_rx(lat);
        total_cnt++; if (lat !== 35)        $display("FAIL single_latency: got %0d want 35", lat); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h3C) $display("FAIL single_rxd: got %h want 3c", rx_data);  else pass_cnt++;
        total_cnt++; if (io_scs !== 1'b1)   $display("FAIL single_scs_gap: got %b want 1", io_scs); else pass_cnt++;
        for (int i = 0; i < 8; i++) got[7-i] = sdi_log[base + i];
        total_cnt++; if (log_n - base !== 8) $display("FAIL single_rise_count: got %0d want 8", log_n - base); else pass_cnt++;
        total_cnt++; if (got !== 8'hA5)     $display("FAIL single_sdi_bits: got %b want 10100101", got); else pass_cnt++;
        idle_cycles(1);
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL single_rxv_pulse: got %b want 0", rx_valid); else pass_cnt++;
        total_cnt++; if (tx_ready !== 1'b0) $display("FAIL single_gap_ready: got %b want 0", tx_ready); else pass_cnt++;
        total_cnt++; if (io_scs !== 1'b1)   $display("FAIL single_gap_scs: got %b want 1", io_scs);     else pass_cnt++;
        idle_cycles(1);
        total_cnt++; if (tx_ready !== 1'b1) $display("FAIL single_ready_after_gap: got %b want 1", tx_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0)     $display("FAIL single_busy_idle: got %b want 0", busy);           else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bit ok; int lat; int base; int r0; int s0; int v0; logic [15:0] got;
        slave_bits = {8'h96, 8'h3C, 48'h0};
        base = log_n; r0 = sck_rises; s0 = scs_rises; v0 = rxv_cnt;
        start_frame(8'h12, 1'b0, ok);
        wait_rx(lat);
        total_cnt++; if (lat !== 35)          $display("FAIL b2b_lat1: got %0d want 35", lat);            else pass_cnt++;
        total_cnt++; if (rx_data !== EXP_RX_96) $display("FAIL b2b_rxd1: got %h want %h", rx_data, EXP_RX_96); else pass_cnt++;
        total_cnt++; if (io_scs !== 1'b0)     $display("FAIL b2b_hold_scs: got %b want 0", io_scs);       else pass_cnt++;
        start_frame(8'h34, 1'b1, ok);
        total_cnt++; if (!ok) $display("FAIL b2b_accept2: got no tx_ready want ready"); else pass_cnt++;
        wait_rx(lat);
        total_cnt++; if (lat < 0)             $display("FAIL b2b_rx2_timeout: got %0d want >=0", lat);    else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h3C)   $display("FAIL b2b_rxd2: got %h want 3c", rx_data);         else pass_cnt++;
        total_cnt++; if (sck_rises - r0 !== 16) $display("FAIL b2b_sck_rises: got %0d want 16", sck_rises - r0); else pass_cnt++;
        total_cnt++; if (scs_rises - s0 !== 1)  $display("FAIL b2b_scs_rises: got %0d want 1", scs_rises - s0);  else pass_cnt++;
        idle_cycles(1);
        total_cnt++; if (rxv_cnt - v0 !== 2)  $display("FAIL b2b_rxv_pulses: got %0d want 2", rxv_cnt - v0); else pass_cnt++;
        for (int i = 0; i < 16; i++) got[15-i] = sdi_log[base + i];
        total_cnt++; if (got !== EXP_SDI_B2B) $display("FAIL b2b_sdi_bits: got %h want %h", got, EXP_SDI_B2B); else pass_cnt++;
    endtask

    task automatic test_abort();
        bit ok; int lat; int base; int v0; logic [7:0] got;
        slave_bits = {8'hE1, 56'h0};
        v0 = rxv_cnt;
        start_frame(8'hFF, 1'b1, ok);
        wait_rises(sck_rises + 4, ok);
        total_cnt++; if (!ok) $display("FAIL abort_reach_rise4: got timeout want 4 rises"); else pass_cnt++;
        abort = 1'b1;
        @(posedge clk); @(negedge clk);
        abort = 1'b0;
        total_cnt++; if (io_sck !== 1'b0) $display("FAIL abort_sck: got %b want 0", io_sck); else pass_cnt++;
        total_cnt++; if (io_scs !== 1'b1) $display("FAIL abort_scs: got %b want 1", io_scs); else pass_cnt++;
        total_cnt++; if (io_sdi !== 1'b0) $display("FAIL abort_sdi: got %b want 0", io_sdi); else pass_cnt++;
        idle_cycles(40);
        total_cnt++; if (rxv_cnt !== v0) $display("FAIL abort_no_rxv: got %0d want %0d", rxv_cnt, v0); else pass_cnt++;
        base = log_n;
        start_frame(8'h00, 1'b1, ok);
        wait_rx(lat);
        total_cnt++; if (lat !== 35)          $display("FAIL abort_next_lat: got %0d want 35", lat);            else pass_cnt++;
        total_cnt++; if (rx_data !== EXP_RX_E1) $display("FAIL abort_next_rxd: got %h want %h", rx_data, EXP_RX_E1); else pass_cnt++;
        for (int i = 0; i < 8; i++) got[7-i] = sdi_log[base + i];
        total_cnt++; if (got !== 8'h00)       $display("FAIL abort_next_sdi: got %h want 00", got);             else pass_cnt++;
    endtask

    task automatic test_abort_idle();
        int n = 0;
        while (!tx_ready && n < 100) begin
            @(posedge clk); @(negedge clk); n++;
        end
        abort = 1'b1; tx_valid = 1'b1; tx_data = 8'h55; tx_last = 1'b1;
        #1;
        total_cnt++; if (tx_ready !== 1'b0) $display("FAIL abort_idle_ready: got %b want 0", tx_ready); else pass_cnt++;
        @(posedge clk); @(negedge clk);
        abort = 1'b0; tx_valid = 1'b0;
        total_cnt++; if (busy !== 1'b0)   $display("FAIL abort_idle_busy: got %b want 0", busy);   else pass_cnt++;
        total_cnt++; if (io_scs !== 1'b1) $display("FAIL abort_idle_scs: got %b want 1", io_scs); else pass_cnt++;
        #1;
        total_cnt++; if (tx_ready !== 1'b1) $display("FAIL abort_idle_ready_back: got %b want 1", tx_ready); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        bit ok; int v0;
        slave_bits = {8'h3C, 56'h0};
        v0 = rxv_cnt;
        start_frame(8'hA5, 1'b1, ok);
        wait_rises(sck_rises + 3, ok);
        total_cnt++; if (!ok) $display("FAIL rst_reach_shift: got timeout want 3 rises"); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++; if (io_scs !== 1'b1)   $display("FAIL rst_async_scs: got %b want 1", io_scs);     else pass_cnt++;
        total_cnt++; if (io_sck !== 1'b0)   $display("FAIL rst_async_sck: got %b want 0", io_sck);     else pass_cnt++;
        total_cnt++; if (busy !== 1'b0)     $display("FAIL rst_async_busy: got %b want 0", busy);       else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++; if (tx_ready !== 1'b0) $display("FAIL rst_ready_early: got %b want 0", tx_ready); else pass_cnt++;
        @(posedge clk); @(negedge clk);
        total_cnt++; if (tx_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", tx_ready);       else pass_cnt++;
        idle_cycles(40);
        total_cnt++; if (rxv_cnt !== v0)    $display("FAIL rst_no_rxv: got %0d want %0d", rxv_cnt, v0); else pass_cnt++;
    endtask

    task automatic test_loopback32();
        int n = 0; int lat = 0;
        while (!w_ready && n < 100) begin
            @(posedge clk); @(negedge clk); n++;
        end
        w_valid = 1'b1; w_data = 32'hDEADBEEF; w_last = 1'b1;
        @(posedge clk); @(negedge clk);
        w_valid = 1'b0; w_data = '0; w_last = 1'b0;
        while (!w_rx_valid && lat < 300) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        total_cnt++; if (lat !== 66) $display("FAIL loop32_latency: got %0d want 66", lat); else pass_cnt++;
        total_cnt++; if (w_rx_data !== 32'hDEADBEEF) $display("FAIL loop32_rxd: got %h want deadbeef", w_rx_data); else pass_cnt++;
        total_cnt++; if (w_scs !== 1'b1 || w_busy !== 1'b1) $display("FAIL loop32_gap: got scs=%b busy=%b want 1/1", w_scs, w_busy); else pass_cnt++;
    endtask

    task automatic test_bit_order();
        bit ok; int lat; int base; logic [7:0] got;
        slave_bits = '0;
        base = log_n;
        start_frame(8'h01, 1'b1, ok);
        wait_rx(lat);
        for (int i = 0; i < 8; i++) got[7-i] = sdi_log[base + i];
        total_cnt++; if (got !== EXP_SDI_01) $display("FAIL order_sdi_bits: got %b want %b", got, EXP_SDI_01); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h00)  $display("FAIL order_rxd: got %h want 00", rx_data);              else pass_cnt++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_abort();
        test_abort_idle();
        test_reset_mid_frame();
        test_loopback32();
        test_bit_order();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
